inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue_if.sv | 28 ++
 rtl/inst_fetch_queue.sv | 134 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Instruction memory bus: one-at-a-time req/gnt request, rvalid/rdata response.
// The master side issues requests; the slave side is the memory.
interface inst_fetch_queue_if #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     mem_req_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic                     mem_gnt_i;
    logic                     mem_rvalid_i;
    logic [WORD_WIDTH-1:0]    mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: word fetcher feeding a small FIFO toward decode/RF.
// Define IFQ_BYPASS_EN to forward a response straight out when the FIFO is empty.
module inst_fetch_queue #(
    parameter int                         WORD_WIDTH    = 32,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_ADDR    = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_addr_i,
    inst_fetch_queue_if.master       mem,
    output logic                     inst_valid_o,
    output logic [WORD_WIDTH-1:0]    inst_o,
    output logic [ADDRESS_WIDTH-1:0] inst_addr_o,
    input  logic                     inst_ready_i,
    output logic                     busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } state_e;

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] req_pc_q;
    logic [WORD_WIDTH-1:0]    word_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [PW-1:0]            rd_ptr_q;
    logic [PW-1:0]            wr_ptr_q;
    logic [CW-1:0]            count_q;

    logic                     req_w;
    logic                     gnt_w;
    logic                     rsp_w;
    logic                     byp_w;
    logic                     push_w;
    logic                     pop_w;
    logic                     fifo_valid_w;
    logic [ADDRESS_WIDTH-1:0] redir_pc_w;
    logic                     unused_w;

    assign redir_pc_w   = {redirect_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_w     = ^redirect_addr_i[1:0];
    assign fifo_valid_w = count_q != '0;

    // One slot stays reserved for the single outstanding request.
    assign req_w = rst_ni && (state_q == REQ) && (count_q < CW'(DEPTH));
    assign gnt_w = req_w && mem.mem_gnt_i;
    assign rsp_w = (state_q == WAIT) && mem.mem_rvalid_i;

`ifdef IFQ_BYPASS_EN
    assign byp_w = rsp_w && !fifo_valid_w && !redirect_i;
`else
    assign byp_w = 1'b0;
`endif

    assign inst_valid_o   = fifo_valid_w || byp_w;
    assign pop_w          = fifo_valid_w && inst_ready_i;
    assign push_w         = rsp_w && !(byp_w && inst_ready_i);
    assign mem.mem_req_o  = req_w;
    assign mem.mem_addr_o = pc_q;
    assign busy_o         = state_q != REQ;

    always_comb begin
        inst_o      = '0;
        inst_addr_o = '0;
        if (fifo_valid_w) begin
            inst_o      = word_q[rd_ptr_q];
            inst_addr_o = addr_q[rd_ptr_q];
        end else if (byp_w) begin
            inst_o      = mem.mem_rdata_i;
            inst_addr_o = req_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !redirect_i && push_w) begin
            word_q[wr_ptr_q] <= mem.mem_rdata_i;
            addr_q[wr_ptr_q] <= req_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= REQ;
            pc_q     <= RESET_ADDR;
            req_pc_q <= RESET_ADDR;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_i) begin
            // Flush; any response still in flight must be swallowed in DROP.
            pc_q     <= redir_pc_w;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            unique case (state_q)
                REQ:     if (gnt_w) state_q <= DROP;
                WAIT:    state_q <= mem.mem_rvalid_i ? REQ : DROP;
                DROP:    if (mem.mem_rvalid_i) state_q <= REQ;
                default: state_q <= REQ;
            endcase
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_w && !pop_w) begin
                count_q <= count_q + 1'b1;
            end else if (!push_w && pop_w) begin
                count_q <= count_q - 1'b1;
            end
            unique case (state_q)
                REQ: begin
                    if (gnt_w) begin
                        state_q  <= WAIT;
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + ADDRESS_WIDTH'(4);
                    end
                end
                WAIT:    if (mem.mem_rvalid_i) state_q <= REQ;
                DROP:    if (mem.mem_rvalid_i) state_q <= REQ;
                default: state_q <= REQ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_w && !redirect_i && !pop_w && count_q == CW'(DEPTH)));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a
// transaction-level queue model of the fetcher and its FIFO.
module tb_inst_fetch_queue;
    localparam int          WW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_A = 32'h0000_0100;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        inst_ready_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        busy_o;

    inst_fetch_queue_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) mem_if ();

    inst_fetch_queue #(
        .WORD_WIDTH(WW),
        .ADDRESS_WIDTH(AW),
        .DEPTH(DEPTH),
        .RESET_ADDR(RST_A)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .redirect_i(redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .mem(mem_if),
        .inst_valid_o(inst_valid_o),
        .inst_o(inst_o),
        .inst_addr_o(inst_addr_o),
        .inst_ready_i(inst_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = RST_A;
    logic [31:0] m_paddr = RST_A;
    bit          m_pend = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_ok = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] grants[$];
    logic [31:0] del_a[$];
    logic [31:0] del_d[$];
    int          del_c[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit byp_now();
`ifdef IFQ_BYPASS_EN
        return q.size() == 0 && m_pend && !m_drop &&
               mem_if.mem_rvalid_i && !redirect_i;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare();
        bit          b;
        bit          ev;
        bit          ereq;
        logic [31:0] ea;
        logic [31:0] ed;
        ereq = rst_ni && !m_pend && q.size() < DEPTH;
        chk("mem_req", 32'(mem_if.mem_req_o), 32'(ereq));
        if (m_ok && rst_ni) begin
            b  = byp_now();
            ev = q.size() > 0 || b;
            ea = q.size() > 0 ? q[0].a : (b ? m_paddr : 32'h0);
            ed = q.size() > 0 ? q[0].d : (b ? mem_if.mem_rdata_i : 32'h0);
            chk("mem_addr", mem_if.mem_addr_o, m_pc);
            chk("inst_valid", 32'(inst_valid_o), 32'(ev));
            chk("inst_addr", inst_addr_o, ea);
            chk("inst", inst_o, ed);
            chk("busy", 32'(busy_o), 32'(m_pend));
            if (ev && inst_ready_i && !redirect_i) begin
                del_a.push_back(ea);
                del_d.push_back(ed);
                del_c.push_back(cyc);
            end
        end
    endtask

    task automatic update();
        bit g;
        bit b;
        bit rv;
        rv = mem_if.mem_rvalid_i;
        if (!rst_ni) begin
            q.delete();
            m_pc    = RST_A;
            m_paddr = RST_A;
            m_pend  = 1'b0;
            m_drop  = 1'b0;
            m_ok    = 1'b1;
            return;
        end
        g = !m_pend && q.size() < DEPTH && mem_if.mem_gnt_i;
        b = byp_now();
        if (g) grants.push_back(m_pc);
        if (redirect_i) begin
            q.delete();
            if (m_pend) begin
                if (rv) begin
                    m_pend = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (g) begin
                m_pend = 1'b1;
                m_drop = 1'b1;
            end
            m_pc = redirect_addr_i & ~32'h3;
        end else begin
            if (q.size() > 0 && inst_ready_i) void'(q.pop_front());
            if (m_pend && rv) begin
                if (!m_drop && !(b && inst_ready_i))
                    q.push_back('{a: m_paddr, d: mem_if.mem_rdata_i});
                m_pend = 1'b0;
                m_drop = 1'b0;
            end else if (g) begin
                m_pend  = 1'b1;
                m_drop  = 1'b0;
                m_paddr = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step();
        #1 compare();
        @(posedge clk_i);
        update();
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic set_in(bit g, bit rv, bit y, bit rd, logic [31:0] ra);
        mem_if.mem_gnt_i    = g;
        mem_if.mem_rvalid_i = rv;
        mem_if.mem_rdata_i  = m_paddr ^ KEY;
        inst_ready_i        = y;
        redirect_i          = rd;
        redirect_addr_i     = ra;
    endtask

    task automatic drive(int gp, int rp, int yp, int dp);
        set_in($urandom_range(99) < 32'(gp),
               m_pend && ($urandom_range(99) < 32'(rp)),
               $urandom_range(99) < 32'(yp),
               $urandom_range(99) < 32'(dp),
               $urandom);
    endtask

    task automatic run(int n, int gp, int rp, int yp, int dp);
        for (int i = 0; i < n; i++) begin
            drive(gp, rp, yp, dp);
            step();
        end
    endtask

    task automatic do_reset(int n);
        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 32'h0);
        #1 chk("rst_req_low", 32'(mem_if.mem_req_o), 32'h0);
        for (int i = 0; i < n; i++) step();
        rst_ni = 1'b1;
    endtask

    task automatic clear_rec();
        grants.delete();
        del_a.delete();
        del_d.delete();
        del_c.delete();
    endtask

    initial begin
        set_in(0, 0, 0, 0, 32'h0);
        @(negedge clk_i);

        // Reset values
        do_reset(2);
        #1;
        chk("rst_req", 32'(mem_if.mem_req_o), 32'h1);
        chk("rst_addr", mem_if.mem_addr_o, 32'h0000_0100);
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        step();

        // Streaming with single-cycle memory
        clear_rec();
        run(14, 100, 100, 100, 0);
        chk("stream_n", 32'(del_a.size()), 32'd6);
        if (del_a.size() >= 3) begin
            chk("stream_a0", del_a[0], 32'h0000_0100);
            chk("stream_a1", del_a[1], 32'h0000_0104);
            chk("stream_a2", del_a[2], 32'h0000_0108);
            chk("stream_d0", del_d[0], 32'hA5A5_A4A5);
            chk("stream_gap", 32'(del_c[1] - del_c[0]), 32'd2);
        end

        // Backpressure: fill, stall, then drain
        do_reset(1);
        clear_rec();
        run(20, 100, 100, 0, 0);
        chk("full_grants", 32'(grants.size()), 32'd4);
        #1 chk("full_req", 32'(mem_if.mem_req_o), 32'h0);
        del_a.delete();
        run(12, 100, 100, 100, 0);
        if (del_a.size() >= 4 && grants.size() >= 5) begin
            chk("drain_a0", del_a[0], 32'h0000_0100);
            chk("drain_a3", del_a[3], 32'h0000_010C);
            chk("resume_addr", grants[4], 32'h0000_0110);
        end else begin
            chk("drain_n", 32'(del_a.size()), 32'd4);
        end

        // Redirect while waiting
        do_reset(1);
        clear_rec();
        set_in(1, 0, 1, 0, 32'h0);
        step();
        set_in(0, 0, 1, 1, 32'h0000_2003);
        step();
        set_in(0, 1, 1, 0, 32'h0);
        #1 chk("drop_req", 32'(mem_if.mem_req_o), 32'h0);
        step();
        set_in(0, 0, 1, 0, 32'h0);
        #1 chk("redir_addr", mem_if.mem_addr_o, 32'h0000_2000);
        chk("redir_req", 32'(mem_if.mem_req_o), 32'h1);
        step();
        del_a.delete();
        run(6, 100, 100, 100, 0);
        if (del_a.size() > 0) chk("redir_first", del_a[0], 32'h0000_2000);
        else chk("redir_n", 32'(del_a.size()), 32'd1);

        // Redirect with rvalid, then redirect with grant
        for (int i = 0; i < 10 && !m_pend; i++) begin
            set_in(1, 0, 1, 0, 32'h0);
            step();
        end
        set_in(1, 1, 1, 1, 32'h0000_3000);
        step();
        set_in(1, 0, 1, 1, 32'h0000_4000);
        step();
        clear_rec();
        run(10, 100, 100, 100, 0);
        if (del_a.size() > 0) chk("redir2_first", del_a[0], 32'h0000_4000);
        else chk("redir2_n", 32'(del_a.size()), 32'd1);

        // pc wrap
        do_reset(1);
        set_in(0, 0, 1, 1, 32'hFFFF_FFFC);
        step();
        clear_rec();
        run(6, 100, 100, 100, 0);
        if (grants.size() >= 2) begin
            chk("wrap_g0", grants[0], 32'hFFFF_FFFC);
            chk("wrap_g1", grants[1], 32'h0000_0000);
        end else begin
            chk("wrap_n", 32'(grants.size()), 32'd2);
        end

        // Reset during WAIT with three entries queued
        do_reset(1);
        run(7, 100, 100, 0, 0);
        #1 chk("fill_busy", 32'(busy_o), 32'h1);
        chk("fill_valid", 32'(inst_valid_o), 32'h1);
        set_in(0, 0, 0, 0, 32'h0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        set_in(0, 1, 1, 0, 32'h0);
        #1 chk("rw_valid", 32'(inst_valid_o), 32'h0);
        chk("rw_busy", 32'(busy_o), 32'h0);
        chk("rw_addr", mem_if.mem_addr_o, 32'h0000_0100);
        step();
        set_in(0, 0, 1, 0, 32'h0);
        #1 chk("late_valid", 32'(inst_valid_o), 32'h0);
        chk("late_busy", 32'(busy_o), 32'h0);
        step();

        // Random traffic
        do_reset(1);
        run(3000, 60, 50, 60, 5);
        run(1500, 70, 70, 20, 3);
        run(1500, 90, 90, 90, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
